// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// clk_div_pkg : shared constants and state encoding for clk_div_monitor
// Rev 1.0
// ============================================================================
package clk_div_pkg;

  localparam int DEF_MAX_N    = 64;
  localparam int DEF_LOCK_CNT = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACQ    = 2'd1;
  localparam state_t ST_TRACK  = 2'd2;
  localparam state_t ST_LOCKED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/clk_div_monitor_edge_sync.sv
`default_nettype none
// ============================================================================
// edge_sync : optional 2-flop synchronizer, one-cycle delay and edge detect
// Rev 1.0
// ============================================================================
module edge_sync #(
  parameter int SYNC_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic s_dly_q;
  logic s_dly_d;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [1:0] sync_q;
      logic [1:0] sync_d;

      always_comb begin
        sync_d = {sync_q[0], clk_in};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= 2'b00;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign s = sync_q[1];
    end else begin : g_bypass
      // Only safe when clk_in is launched from clk itself.
      assign s = clk_in;
    end
  endgenerate

  always_comb begin
    s_dly_d = s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_dly_q <= 1'b0;
    end else begin
      s_dly_q <= s_dly_d;
    end
  end

  assign rise = s & ~s_dly_q;
  assign fall = ~s & s_dly_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// clk_div_monitor : measures period/duty of a divided clock, locks on ratio
// Rev 1.0
// ============================================================================
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int MAX_N    = DEF_MAX_N,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int SYNC_EN  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_in,
  output logic [$clog2(MAX_N+1)-1:0]   ratio,
  output logic                         locked,
  output logic                         err_period,
  output logic                         err_stall
);

  localparam int CW = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] C_MAX  = CW'(MAX_N);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [3:0]    C_LOCK = 4'(LOCK_CNT);

  logic s;
  logic rise;
  logic fall;

  edge_sync #(
    .SYNC_EN (SYNC_EN)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clk_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q,  hi_cnt_d;
  logic [CW-1:0] hi_q,      hi_d;
  logic [CW-1:0] ref_q,     ref_d;
  logic [3:0]    match_q,   match_d;
  state_t        state_q,   state_d;
  logic [CW-1:0] ratio_q,   ratio_d;
  logic          locked_q,  locked_d;
  logic          err_period_q, err_period_d;
  logic          err_stall_q,  err_stall_d;

  logic [CW-1:0] meas;
  logic          duty_ok;
  logic          period_ok;
  logic          timeout;

  assign meas      = per_cnt_q + C_ONE;
  assign duty_ok   = ({hi_q, 1'b0} == {1'b0, meas});
  assign period_ok = (meas == ref_q) && duty_ok;
  // A rise restarts the period, so it always wins over a saturated counter.
  assign timeout   = (per_cnt_q == C_MAX) && !rise;

  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    hi_d      = hi_q;
    if (rise) begin
      per_cnt_d = '0;
      hi_cnt_d  = C_ONE;
    end else begin
      if (per_cnt_q != C_MAX) per_cnt_d = per_cnt_q + C_ONE;
      if (s && (hi_cnt_q != C_MAX)) hi_cnt_d = hi_cnt_q + C_ONE;
    end
    if (fall) hi_d = hi_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    match_d      = match_q;
    ratio_d      = ratio_q;
    locked_d     = locked_q;
    err_period_d = 1'b0;
    err_stall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          state_d = ST_TRACK;
          ref_d   = meas;
          match_d = 4'd1;
        end
      end
      ST_TRACK: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          if (period_ok) begin
            match_d = match_q + 4'd1;
            if ((match_q + 4'd1) == C_LOCK) begin
              state_d  = ST_LOCKED;
              ratio_d  = ref_q;
              locked_d = 1'b1;
            end
          end else begin
            ref_d   = meas;
            match_d = 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (timeout) begin
          state_d     = ST_IDLE;
          locked_d    = 1'b0;
          err_stall_d = 1'b1;
        end else if (rise && !period_ok) begin
          state_d      = ST_TRACK;
          locked_d     = 1'b0;
          err_period_d = 1'b1;
          ref_d        = meas;
          match_d      = 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      hi_q         <= '0;
      ref_q        <= '0;
      match_q      <= 4'd0;
      state_q      <= ST_IDLE;
      ratio_q      <= '0;
      locked_q     <= 1'b0;
      err_period_q <= 1'b0;
      err_stall_q  <= 1'b0;
    end else begin
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      hi_q         <= hi_d;
      ref_q        <= ref_d;
      match_q      <= match_d;
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      locked_q     <= locked_d;
      err_period_q <= err_period_d;
      err_stall_q  <= err_stall_d;
    end
  end

  assign ratio      = ratio_q;
  assign locked     = locked_q;
  assign err_period = err_period_q;
  assign err_stall  = err_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// tb_clk_div_monitor : directed self-checking bench for clk_div_monitor
// Rev 1.0
// ============================================================================
module tb_clk_div_monitor;
  import clk_div_pkg::*;

  localparam int MAX_N = 64;
  localparam int CW    = $clog2(MAX_N + 1);

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          clk_in = 1'b0;
  logic [CW-1:0] ratio;
  logic          locked;
  logic          err_period;
  logic          err_stall;

  clk_div_monitor #(
    .MAX_N    (64),
    .LOCK_CNT (4),
    .SYNC_EN  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .ratio      (ratio),
    .locked     (locked),
    .err_period (err_period),
    .err_stall  (err_stall)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk) cyc++;

  // Divided-clock source: hi/lo changes take effect at the next period start.
  bit gen_en = 1'b0;
  int gen_hi = 2, gen_lo = 2, req_hi = 2, req_lo = 2, ph = 0;
  int rise_cnt = 0, first_rise_cyc = 0, last_rise_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (!gen_en) begin
      clk_in = 1'b0;
    end else begin
      if (ph == 0) begin
        gen_hi = req_hi;
        gen_lo = req_lo;
      end
      if (ph < gen_hi) begin
        if (clk_in == 1'b0) begin
          rise_cnt++;
          if (rise_cnt == 1) first_rise_cyc = cyc;
          last_rise_cyc = cyc;
        end
        clk_in = 1'b1;
      end else begin
        clk_in = 1'b0;
      end
      ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
    end
  end

  int n_errp = 0, n_errs = 0;
  always @(negedge clk) begin
    #1;
    if (err_period === 1'b1) n_errp++;
    if (err_stall === 1'b1) n_errs++;
  end

  task automatic do_reset();
    gen_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_div(input int hi, input int lo);
    @(negedge clk);
    gen_hi = hi; gen_lo = lo; req_hi = hi; req_lo = lo;
    ph = 0; rise_cnt = 0;
    gen_en = 1'b1;
  endtask

  task automatic wait_lock(input int bound, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (locked === 1'b1) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (ratio !== '0) begin tests_failed++; $display("FAIL reset_ratio got=%0d exp=0", ratio); end
    tests_run++;
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got=%b exp=0", locked); end
    tests_run++;
    if (err_period !== 1'b0) begin tests_failed++; $display("FAIL reset_err_period got=%b exp=0", err_period); end
    tests_run++;
    if (err_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_err_stall got=%b exp=0", err_stall); end
  endtask

  task automatic test_lock_n4();
    bit ok; int at; int e0;
    do_reset();
    e0 = n_errp + n_errs;
    start_div(2, 2);
    wait_lock(100, ok, at);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL n4_lock got=timeout exp=locked"); end
    tests_run++;
    if (at != first_rise_cyc + 19) begin tests_failed++; $display("FAIL n4_lock_time got=%0d exp=%0d", at, first_rise_cyc + 19); end
    tests_run++;
    if (ratio !== 7'd4) begin tests_failed++; $display("FAIL n4_ratio got=%0d exp=4", ratio); end
    repeat (40) @(negedge clk);
    tests_run++;
    if (locked !== 1'b1 || ratio !== 7'd4) begin tests_failed++; $display("FAIL n4_hold got=%b/%0d exp=1/4", locked, ratio); end
    tests_run++;
    if (n_errp + n_errs != e0) begin tests_failed++; $display("FAIL n4_no_err got=%0d exp=0", n_errp + n_errs - e0); end
  endtask

  task automatic test_ratio_change();
    bit saw_unlock = 0, relocked = 0, hold_bad = 0, err_lock_bad = 0;
    int errs = 0, err_at = -1, lock_at = -1, s0;
    s0 = n_errs;
    req_hi = 3; req_lo = 3;
    for (int i = 0; i < 200 && !relocked; i++) begin
      @(negedge clk);
      if (err_period === 1'b1) begin
        errs++;
        err_at = cyc;
        if (locked !== 1'b0) err_lock_bad = 1;
      end
      if (locked === 1'b0) begin
        saw_unlock = 1;
        if (ratio !== 7'd4) hold_bad = 1;
      end else if (saw_unlock) begin
        relocked = 1;
        lock_at = cyc;
      end
    end
    tests_run++;
    if (!relocked) begin tests_failed++; $display("FAIL chg_relock got=timeout exp=relock"); end
    tests_run++;
    if (errs != 1) begin tests_failed++; $display("FAIL chg_err_count got=%0d exp=1", errs); end
    tests_run++;
    if (err_lock_bad) begin tests_failed++; $display("FAIL chg_unlock_on_err got=locked exp=unlocked"); end
    tests_run++;
    if (hold_bad) begin tests_failed++; $display("FAIL chg_ratio_hold got=changed exp=4"); end
    tests_run++;
    if (ratio !== 7'd6) begin tests_failed++; $display("FAIL chg_ratio got=%0d exp=6", ratio); end
    tests_run++;
    if (lock_at - err_at != 18) begin tests_failed++; $display("FAIL chg_relock_time got=%0d exp=18", lock_at - err_at); end
    tests_run++;
    if (n_errs != s0) begin tests_failed++; $display("FAIL chg_no_stall got=%0d exp=0", n_errs - s0); end
  endtask

  task automatic test_stall();
    bit ok; int at; int p0; bit seen = 0; int st_at = -1;
    do_reset();
    start_div(4, 4);
    wait_lock(200, ok, at);
    tests_run++;
    if (!ok || ratio !== 7'd8) begin tests_failed++; $display("FAIL stall_prelock got=%b/%0d exp=1/8", ok, ratio); end
    p0 = n_errp;
    repeat (5) @(negedge clk);
    gen_en = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      if (err_stall === 1'b1) begin
        seen = 1;
        st_at = cyc;
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL stall_unlock got=%b exp=0", locked); end
        tests_run++;
        if (dut.state_q !== ST_IDLE) begin tests_failed++; $display("FAIL stall_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
      end
    end
    tests_run++;
    if (st_at != last_rise_cyc + 68) begin tests_failed++; $display("FAIL stall_time got=%0d exp=%0d", st_at, last_rise_cyc + 68); end
    @(negedge clk);
    tests_run++;
    if (err_stall !== 1'b0) begin tests_failed++; $display("FAIL stall_pulse_width got=%b exp=0", err_stall); end
    tests_run++;
    if (ratio !== 7'd8) begin tests_failed++; $display("FAIL stall_ratio_hold got=%0d exp=8", ratio); end
    tests_run++;
    if (n_errp != p0) begin tests_failed++; $display("FAIL stall_no_period_err got=%0d exp=0", n_errp - p0); end
    start_div(4, 4);
    wait_lock(200, ok, at);
    tests_run++;
    if (!ok || ratio !== 7'd8) begin tests_failed++; $display("FAIL stall_relock got=%b/%0d exp=1/8", ok, ratio); end
  endtask

  task automatic test_odd();
    bit any_lock = 0; int e0;
    do_reset();
    e0 = n_errp + n_errs;
    start_div(3, 2);
    repeat (300) begin
      @(negedge clk);
      if (locked === 1'b1) any_lock = 1;
    end
    tests_run++;
    if (any_lock) begin tests_failed++; $display("FAIL odd_no_lock got=locked exp=unlocked"); end
    tests_run++;
    if (n_errp + n_errs != e0 || ratio !== '0) begin tests_failed++; $display("FAIL odd_quiet got=%0d errs ratio %0d exp=0/0", n_errp + n_errs - e0, ratio); end
  endtask

  task automatic test_reset_midlock();
    bit ok; int at;
    do_reset();
    start_div(2, 2);
    wait_lock(100, ok, at);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rst_prelock got=timeout exp=locked"); end
    gen_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (locked !== 1'b0 || ratio !== '0 || err_period !== 1'b0 || err_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async got=%b/%0d/%b/%b exp=0/0/0/0", locked, ratio, err_period, err_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    start_div(2, 2);
    wait_lock(100, ok, at);
    tests_run++;
    if (!ok || at != first_rise_cyc + 19) begin tests_failed++; $display("FAIL rst_relock_time got=%0d exp=%0d", at, first_rise_cyc + 19); end
    tests_run++;
    if (ratio !== 7'd4) begin tests_failed++; $display("FAIL rst_relock_ratio got=%0d exp=4", ratio); end
  endtask

  task automatic test_boundaries();
    bit ok; int at; int e0; bit any_lock = 0;
    do_reset();
    start_div(1, 1);
    wait_lock(60, ok, at);
    tests_run++;
    if (!ok || at != first_rise_cyc + 11) begin tests_failed++; $display("FAIL n2_lock_time got=%0d exp=%0d", at, first_rise_cyc + 11); end
    tests_run++;
    if (ratio !== 7'd2) begin tests_failed++; $display("FAIL n2_ratio got=%0d exp=2", ratio); end

    do_reset();
    e0 = n_errp + n_errs;
    start_div(32, 32);
    wait_lock(400, ok, at);
    tests_run++;
    if (!ok || at != first_rise_cyc + 259) begin tests_failed++; $display("FAIL n64_lock_time got=%0d exp=%0d", at, first_rise_cyc + 259); end
    tests_run++;
    if (ratio !== 7'd64) begin tests_failed++; $display("FAIL n64_ratio got=%0d exp=64", ratio); end
    tests_run++;
    if (n_errp + n_errs != e0) begin tests_failed++; $display("FAIL n64_no_err got=%0d exp=0", n_errp + n_errs - e0); end

    do_reset();
    e0 = n_errp + n_errs;
    start_div(33, 33);
    repeat (600) begin
      @(negedge clk);
      if (locked === 1'b1) any_lock = 1;
    end
    tests_run++;
    if (any_lock) begin tests_failed++; $display("FAIL n66_no_lock got=locked exp=unlocked"); end
    @(negedge clk);
    tests_run++;
    if (n_errp + n_errs != e0) begin tests_failed++; $display("FAIL n66_no_err got=%0d exp=0", n_errp + n_errs - e0); end
  endtask

  initial begin
    test_reset();
    test_lock_n4();
    test_ratio_change();
    test_stall();
    test_odd();
    test_reset_midlock();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_monitor.md
# clk_div_monitor

Receive-side companion to the team's even clock divider. Samples a divided clock (`clk_in`) in the fast `clk` domain, measures its period and high time in `clk` cycles, and reports the division ratio once it has been stable for `LOCK_CNT` periods. It also flags ratio changes and stalls. It sits on the consumer side of any divided-clock net, for bring-up checks and runtime clock-health monitoring.

## Interface
Parameters:
- `MAX_N`, 64: largest ratio measured; longer periods count as a stall.
- `LOCK_CNT`, 4: consecutive matching periods required to lock; legal range 2..15.
- `SYNC_EN`, 1: 1 puts a 2-flop synchronizer on `clk_in`; 0 uses the input directly (same-clock source only).

Ports (`CW = $clog2(MAX_N+1)`):
- `clk`  in  1  fast reference clock; all logic on its posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_in`  in  1  divided clock under test, treated as data.
- `ratio`  out  CW  last locked ratio; held through loss of lock.
- `locked`  out  1  high while in LOCKED.
- `err_period`  out  1  one-cycle pulse on a period or duty mismatch while LOCKED.
- `err_stall`  out  1  one-cycle pulse on a timeout while LOCKED.

## Operation
Front end:
- `s` is the synchronized sample of `clk_in`; `s_d` is `s` delayed one cycle.
- `rise = s & ~s_d`; `fall = ~s & s_d`.

Counters:
- `per_cnt`: 0 on a rise cycle, otherwise +1, saturating at `MAX_N`.
- On a rise, `meas = per_cnt + 1`. A divide-by-N source therefore gives `meas = N`.
- `hi_cnt`: 1 on a rise cycle, +1 on each other cycle with `s = 1`. It is captured into `hi` on a fall.
- Duty is good when `2*hi == meas`, i.e. exactly 50%. Odd ratios never lock, by design.

State machine (rise-driven):
- IDLE → ACQ on the first rise. The partial first period is discarded.
- ACQ → TRACK on a rise: `ref = meas`, `match = 1`.
- TRACK, on a rise:
  - If `meas == ref` and duty is good, `match` increments. When `match` reaches `LOCK_CNT`, go to LOCKED, set `ratio = ref`, and set `locked = 1`.
  - Otherwise set `ref = meas`, `match = 1`, and stay in TRACK.
- LOCKED, on a rise with a mismatch or bad duty: pulse `err_period`, clear `locked`, set `ref = meas`, `match = 1`, go to TRACK.
- Timeout, in any state other than IDLE: when `per_cnt == MAX_N` and there is no rise that cycle, go to IDLE. If the block was LOCKED, also pulse `err_stall` and clear `locked`. This covers stuck-high, stuck-low and any period greater than `MAX_N`.
- A rise and a timeout cannot occur in the same cycle.

Reset:
- `rst` clears, immediately: all outputs, the synchronizer, `s_d`, all counters, `ref`, `match`, and the state (to IDLE).
- Reset mid-lock behaves as a cold start.
- The first rise after release is treated like any other.

## Timing
- Detection latency from `clk_in` going high to `rise`: 3 `clk` cycles with `SYNC_EN = 1`, 1 cycle with `SYNC_EN = 0`. The same latency applies to a fall, so measured values are unaffected.
- `locked` asserts on the `clk` edge that ends the cycle in which rise number `LOCK_CNT + 1` is detected. For N = 4 and `LOCK_CNT = 4`, that is 16 cycles after the first detected rise.
- `err_period` and `err_stall` are high for exactly one cycle.
- `locked` and `ratio` update on the same edge.
- `ratio` does not change while unlocked.
- Minimum measurable N is 2.

## Structure
- Shared package `clk_div_pkg`:
  - state encoding localparams `ST_IDLE`, `ST_ACQ`, `ST_TRACK`, `ST_LOCKED`;
  - default `MAX_N` / `LOCK_CNT` constants.
- One sub-module, `edge_sync`: optional 2-flop synchronizer plus the `s_d` register, with `rise` and `fall` outputs. The counters and FSM stay in the top module.

## Test plan
- Divider N = 4 drives `clk_in` → `ratio = 4`, `locked` asserts 16 cycles after the first detected rise, no error pulses.
- Locked at N = 4, then switch to N = 6 → single `err_period` pulse at the first 6-cycle rise, `locked = 0`, relock with `ratio = 6` after 4 matching periods; `ratio` holds 4 in between.
- Locked at N = 8, then hold `clk_in` low → `err_stall` pulse 64 cycles after the last rise, `locked = 0`, state IDLE; a subsequent N = 8 source relocks.
- Asymmetric waveform, 3 high / 2 low (N = 5) → never locks, no error pulses.
- Assert `rst` mid-lock for 1 cycle → outputs 0 asynchronously; after release, relock at the same ratio 16 cycles after the first new detected rise (N = 4).
- Boundaries: N = 2 and N = 64 both lock with the correct `ratio`; N = 66 never locks and causes no error pulse.
